mem_arbiter: RTL and testbench

- Shares the single-ported stalling data/instruction memory between the fetch port (I, read-only) and the memory-stage port (D, read/write) of the pipelined core.
- Latches the winning request, holds the memory command until the memory reports done, and returns data and a one-cycle valid to the winner.
- Stalls the loser and the winner until their access completes.
- Includes a watchdog that aborts hung transactions.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   arb_gnt_e   : grant target / last-grant pointer (GNT_I, GNT_D)
//   AW_DEF/DW_DEF : default address and data widths
package mem_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch I, memory-stage D), the
// arbiter and the single-ported memory.
//   slave  : arbiter view (requests/memory response in, data/valid/stall/command out)
//   master : environment view (requesters + memory), the mirror image
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          IReq;
    logic [AW-1:0] IAddr;
    logic [DW-1:0] IData;
    logic          IValid;
    logic          IStall;

    logic          DRd;
    logic          DWr;
    logic [AW-1:0] DAddr;
    logic [DW-1:0] DWData;
    logic [DW-1:0] DData;
    logic          DValid;
    logic          DStall;

    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemData;
    logic          MemRead;
    logic          MemWrite;
    logic [DW-1:0] MemReadData;
    logic          MemDone;

    logic          Err;

    modport slave (
        input  IReq, IAddr, DRd, DWr, DAddr, DWData, MemReadData, MemDone,
        output IData, IValid, IStall, DData, DValid, DStall,
               MemAddr, MemData, MemRead, MemWrite, Err
    );

    modport master (
        output IReq, IAddr, DRd, DWr, DAddr, DWData, MemReadData, MemDone,
        input  IData, IValid, IStall, DData, DValid, DStall,
               MemAddr, MemData, MemRead, MemWrite, Err
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and data (D) requests.
// Build option MEM_ARB_RR_EN: when both request, the side that did not win
// last time wins. Without it D always beats I and last_gnt_i is ignored.
//   i_req_i     : fetch request
//   d_req_i     : data request (read or write)
//   last_gnt_i  : last-grant pointer
//   gnt_valid_o : some request is present
//   gnt_o       : winner
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     i_req_i,
    input  logic     d_req_i,
    input  arb_gnt_e last_gnt_i,
    output logic     gnt_valid_o,
    output arb_gnt_e gnt_o
);

    assign gnt_valid_o = i_req_i | d_req_i;

    always_comb begin
        gnt_o = GNT_I;
        if (d_req_i && !i_req_i) begin
            gnt_o = GNT_D;
        end else if (d_req_i && i_req_i) begin
`ifdef MEM_ARB_RR_EN
            gnt_o = (last_gnt_i == GNT_D) ? GNT_I : GNT_D;
`else
            gnt_o = GNT_D;
`endif
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one stalling single-ported memory between the fetch port
// (read-only) and the memory-stage port (read/write). One transaction at a
// time; the command is registered in IDLE and held until MemDone, then the
// winner gets a one-cycle Valid. A watchdog aborts BUSY after TIMEOUT cycles
// without MemDone and sets the sticky Err (also set on DRd&DWr conflicts).
// Build option MEM_ARB_RR_EN selects round-robin instead of D-over-I priority.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : requester ports, memory command/response, Err
//
//   state  | meaning
//   IDLE   | sample requests, register winner's command
//   BUSY_I | fetch read in flight, wait for MemDone or timeout
//   BUSY_D | data read/write in flight, wait for MemDone or timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic         Clk,
    input  logic         Rst_n,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_BUSY_I = BUSY_I;
    localparam logic [1:0] S_BUSY_D = BUSY_D;
    localparam int         TW       = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;

    logic     d_req;
    logic     gnt_vld;
    arb_gnt_e gnt;
    arb_gnt_e last_gnt;
    logic     i_done, d_done;

    assign d_req = bus.DRd | bus.DWr;

    mem_arb_pick u_pick (
        .i_req_i     (bus.IReq),
        .d_req_i     (d_req),
        .last_gnt_i  (last_gnt),
        .gnt_valid_o (gnt_vld),
        .gnt_o       (gnt)
    );

`ifdef MEM_ARB_RR_EN
    arb_gnt_e last_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                           last_q <= GNT_I;
        else if (state_q == S_IDLE && gnt_vld) last_q <= gnt;
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = GNT_I;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (gnt_vld) begin
                    if (gnt == GNT_D) begin
                        state_d = S_BUSY_D;
                        addr_d  = bus.DAddr;
                        // Read+write together: the write wins, flagged as an error.
                        wr_d    = bus.DWr;
                        rd_d    = bus.DRd & ~bus.DWr;
                        wdata_d = bus.DWr ? bus.DWData : '0;
                        if (bus.DRd && bus.DWr) err_d = 1'b1;
                    end else begin
                        state_d = S_BUSY_I;
                        addr_d  = bus.IAddr;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                // timer_q holds the number of BUSY cycles already completed.
                if (bus.MemDone || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    wdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    timer_d = '0;
                    if (!bus.MemDone) err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                wdata_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign i_done = (state_q == S_BUSY_I) & bus.MemDone;
    assign d_done = (state_q == S_BUSY_D) & bus.MemDone;

    assign bus.IValid   = i_done;
    assign bus.IData    = i_done ? bus.MemReadData : '0;
    assign bus.DValid   = d_done;
    assign bus.DData    = (d_done & rd_q) ? bus.MemReadData : '0;
    assign bus.IStall   = bus.IReq & ~i_done;
    assign bus.DStall   = d_req & ~d_done;
    assign bus.MemAddr  = addr_q;
    assign bus.MemData  = wdata_q;
    assign bus.MemRead  = rd_q;
    assign bus.MemWrite = wr_q;
    assign bus.Err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int RAND_CYCLES = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.IReq = 1'b1; bus.DWr = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.MemAddr !== 16'h0 || bus.MemData !== 16'h0) begin
            errors++; $display("FAIL reset_cmd got rd=%b wr=%b a=%h d=%h exp all 0", bus.MemRead, bus.MemWrite, bus.MemAddr, bus.MemData);
        end
        checks++;
        if (bus.Err !== 1'b0 || bus.IValid !== 1'b0 || bus.DValid !== 1'b0) begin
            errors++; $display("FAIL reset_flags got err=%b iv=%b dv=%b exp 0", bus.Err, bus.IValid, bus.DValid);
        end
        checks++;
        if (bus.IStall !== 1'b1 || bus.DStall !== 1'b1) begin
            errors++; $display("FAIL reset_stall got is=%b ds=%b exp 1 1", bus.IStall, bus.DStall);
        end
        tick();
        bus.IReq = 1'b0; bus.DWr = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        bus.IReq = 1'b1; bus.IAddr = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus.IStall !== 1'b1 || bus.IValid !== 1'b0 || bus.MemRead !== 1'b0) begin
            errors++; $display("FAIL fetch_c0 got is=%b iv=%b rd=%b exp 1 0 0", bus.IStall, bus.IValid, bus.MemRead);
        end
        tick();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0 || bus.MemAddr !== 16'h0010) begin
            errors++; $display("FAIL fetch_cmd got rd=%b wr=%b a=%h exp 1 0 0010", bus.MemRead, bus.MemWrite, bus.MemAddr);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (bus.IValid !== 1'b1 || bus.IData !== 16'hBEEF || bus.IStall !== 1'b0) begin
            errors++; $display("FAIL fetch_c1 got iv=%b id=%h is=%b exp 1 beef 0", bus.IValid, bus.IData, bus.IStall);
        end
        tick();
        bus.IReq = 1'b0; bus.MemDone = 1'b0; bus.MemReadData = 16'h0;
        @(negedge clk);
        checks++;
        if (bus.MemRead !== 1'b0 || bus.IValid !== 1'b0) begin
            errors++; $display("FAIL fetch_end got rd=%b iv=%b exp 0 0", bus.MemRead, bus.IValid);
        end
        tick();
    endtask

    task automatic test_data_write();
        bus.DWr = 1'b1; bus.DAddr = 16'h0100; bus.DWData = 16'h1234; bus.MemReadData = 16'hA5A5;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.MemDone = (k == 3);
            checks++;
            if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.MemAddr !== 16'h0100 || bus.MemData !== 16'h1234) begin
                errors++; $display("FAIL wr_cmd k=%0d got wr=%b rd=%b a=%h d=%h exp 1 0 0100 1234", k, bus.MemWrite, bus.MemRead, bus.MemAddr, bus.MemData);
            end
            @(negedge clk);
            checks++;
            if (bus.DValid !== (k == 3) || bus.DStall !== (k != 3) || (k == 3 && bus.DData !== 16'h0)) begin
                errors++; $display("FAIL wr_resp k=%0d got dv=%b ds=%b dd=%h", k, bus.DValid, bus.DStall, bus.DData);
            end
            tick();
        end
        bus.DWr = 1'b0; bus.MemDone = 1'b0;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.MemRead !== 1'b0) begin
            errors++; $display("FAIL wr_end got wr=%b rd=%b exp 0 0", bus.MemWrite, bus.MemRead);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.IReq = 1'b1; bus.IAddr = 16'h0020; bus.DRd = 1'b1; bus.DAddr = 16'h0200;
        tick();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemAddr !== 16'h0200) begin
            errors++; $display("FAIL sim_first got rd=%b a=%h exp 1 0200", bus.MemRead, bus.MemAddr);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'h1111;
        @(negedge clk);
        checks++;
        if (bus.DValid !== 1'b1 || bus.DData !== 16'h1111 || bus.IValid !== 1'b0 || bus.IStall !== 1'b1) begin
            errors++; $display("FAIL sim_d got dv=%b dd=%h iv=%b is=%b", bus.DValid, bus.DData, bus.IValid, bus.IStall);
        end
        tick();
        bus.DRd = 1'b0; bus.MemDone = 1'b0;
        checks++;
        if (bus.MemRead !== 1'b0) begin
            errors++; $display("FAIL sim_idle got rd=%b exp 0", bus.MemRead);
        end
        tick();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemAddr !== 16'h0020) begin
            errors++; $display("FAIL sim_second got rd=%b a=%h exp 1 0020", bus.MemRead, bus.MemAddr);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'h2222;
        @(negedge clk);
        checks++;
        if (bus.IValid !== 1'b1 || bus.IData !== 16'h2222 || bus.DValid !== 1'b0) begin
            errors++; $display("FAIL sim_i got iv=%b id=%h dv=%b", bus.IValid, bus.IData, bus.DValid);
        end
        tick();
        bus.IReq = 1'b0; bus.MemDone = 1'b0;
        tick();
    endtask

    // Reference: requesters follow the hold-until-Valid protocol, memory
    // answers after a random latency; expected data comes from ref_mem,
    // which is updated only when the bench's own write completes.
    task automatic test_random();
        logic [15:0] ref_mem [16];
        logic [15:0] env_mem [16];
        logic        i_pend = 0, d_pend = 0, d_wr = 0;
        logic [3:0]  i_a = 0, d_a = 0;
        logic [15:0] d_wd = 0;
        int          i_gap = 0, d_gap = 0, lat = 0;
        logic        p_i = 0, p_d = 0, p_wr = 0;
        logic [3:0]  p_ia = 0, p_da = 0;
        logic [15:0] p_wd = 0;
        logic        m_busy = 0, m_gd = 0, m_wr = 0, m_done = 0;
        logic [3:0]  m_a = 0;
        logic [15:0] m_wd = 0;
        logic        iv_seen = 0, dv_seen = 0, exp_iv, exp_dv;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = 16'($urandom);
            env_mem[k] = ref_mem[k];
        end
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            tick();
            if (m_busy) begin
                if (m_done) m_busy = 0;
            end else if (p_i || p_d) begin
                m_busy = 1; m_gd = p_d; m_wr = p_d & p_wr;
                m_a = p_d ? p_da : p_ia; m_wd = p_wd;
                lat = $urandom_range(0, 3);
            end
            m_done = 0;
            if (m_busy) begin
                m_done = (lat == 0);
                if (lat > 0) lat--;
            end
            checks++;
            if (bus.MemRead !== (m_busy && !m_wr) || bus.MemWrite !== (m_busy && m_wr)) begin
                errors++; $display("FAIL rnd_dir cyc=%0d got rd=%b wr=%b exp rd=%b wr=%b", cyc, bus.MemRead, bus.MemWrite, m_busy && !m_wr, m_busy && m_wr);
            end
            checks++;
            if (bus.MemAddr !== (m_busy ? {12'h0, m_a} : 16'h0)) begin
                errors++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, bus.MemAddr, m_busy ? {12'h0, m_a} : 16'h0);
            end
            if (!m_busy || m_wr) begin
                checks++;
                if (bus.MemData !== (m_busy ? m_wd : 16'h0)) begin
                    errors++; $display("FAIL rnd_wdata cyc=%0d got %h exp %h", cyc, bus.MemData, m_busy ? m_wd : 16'h0);
                end
            end
            bus.MemDone = m_done;
            bus.MemReadData = (m_done && bus.MemRead) ? env_mem[bus.MemAddr[3:0]] : 16'($urandom);
            if (m_done && bus.MemWrite) env_mem[bus.MemAddr[3:0]] = bus.MemData;
            if (iv_seen) begin i_pend = 0; i_gap = $urandom_range(0, 3); end
            if (dv_seen) begin d_pend = 0; d_gap = $urandom_range(0, 3); end
            if (!i_pend && cyc < RAND_CYCLES - 24) begin
                if (i_gap == 0) begin i_pend = 1; i_a = 4'($urandom); end
                else i_gap--;
            end
            if (!d_pend && cyc < RAND_CYCLES - 24) begin
                if (d_gap == 0) begin
                    d_pend = 1; d_a = 4'($urandom); d_wr = 1'($urandom_range(0, 1)); d_wd = 16'($urandom);
                end else d_gap--;
            end
            bus.IReq = i_pend; bus.IAddr = {12'h0, i_a};
            bus.DRd = d_pend & ~d_wr; bus.DWr = d_pend & d_wr;
            bus.DAddr = {12'h0, d_a}; bus.DWData = d_wd;
            p_i = i_pend; p_d = d_pend; p_wr = d_wr; p_ia = i_a; p_da = d_a; p_wd = d_wd;
            @(negedge clk);
            exp_iv = m_busy && m_done && !m_gd;
            exp_dv = m_busy && m_done && m_gd;
            checks++;
            if (bus.IValid !== exp_iv || bus.DValid !== exp_dv) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got iv=%b dv=%b exp iv=%b dv=%b", cyc, bus.IValid, bus.DValid, exp_iv, exp_dv);
            end
            checks++;
            if (bus.IStall !== (i_pend && !exp_iv) || bus.DStall !== (d_pend && !exp_dv)) begin
                errors++; $display("FAIL rnd_stall cyc=%0d got is=%b ds=%b exp is=%b ds=%b", cyc, bus.IStall, bus.DStall, i_pend && !exp_iv, d_pend && !exp_dv);
            end
            if (exp_iv) begin
                checks++;
                if (bus.IData !== ref_mem[i_a]) begin
                    errors++; $display("FAIL rnd_idata cyc=%0d got %h exp %h", cyc, bus.IData, ref_mem[i_a]);
                end
            end
            if (exp_dv) begin
                checks++;
                if (bus.DData !== (d_wr ? 16'h0 : ref_mem[d_a])) begin
                    errors++; $display("FAIL rnd_ddata cyc=%0d got %h exp %h", cyc, bus.DData, d_wr ? 16'h0 : ref_mem[d_a]);
                end
                if (d_wr) ref_mem[d_a] = d_wd;
            end
            iv_seen = exp_iv; dv_seen = exp_dv;
        end
        checks++;
        if (m_busy || i_pend || d_pend || bus.Err !== 1'b0) begin
            errors++; $display("FAIL rnd_drain got busy=%b ip=%b dp=%b err=%b exp all 0", m_busy, i_pend, d_pend, bus.Err);
        end
        tick();
        bus.MemDone = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        bus.DRd = 1'b1; bus.DWr = 1'b1; bus.DAddr = 16'h0300; bus.DWData = 16'hCAFE;
        @(negedge clk);
        checks++;
        if (bus.Err !== 1'b0) begin
            errors++; $display("FAIL conf_pre got err=%b exp 0", bus.Err);
        end
        tick();
        checks++;
        if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0 || bus.MemData !== 16'hCAFE || bus.Err !== 1'b1) begin
            errors++; $display("FAIL conf_cmd got wr=%b rd=%b d=%h err=%b exp 1 0 cafe 1", bus.MemWrite, bus.MemRead, bus.MemData, bus.Err);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'h7777;
        @(negedge clk);
        checks++;
        if (bus.DValid !== 1'b1 || bus.DData !== 16'h0) begin
            errors++; $display("FAIL conf_resp got dv=%b dd=%h exp 1 0000", bus.DValid, bus.DData);
        end
        tick();
        bus.DRd = 1'b0; bus.DWr = 1'b0; bus.MemDone = 1'b0;
        checks++;
        if (bus.Err !== 1'b1 || bus.MemWrite !== 1'b0) begin
            errors++; $display("FAIL conf_end got err=%b wr=%b exp 1 0", bus.Err, bus.MemWrite);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.DRd = 1'b1; bus.DAddr = 16'h0400;
        tick();
        checks++;
        if (bus.MemRead !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy got rd=%b exp 1", bus.MemRead);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'h4444;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0 || bus.DValid !== 1'b0 || bus.Err !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop got rd=%b wr=%b dv=%b err=%b exp 0 0 0 0", bus.MemRead, bus.MemWrite, bus.DValid, bus.Err);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.DValid !== 1'b0 || bus.MemRead !== 1'b0) begin
                errors++; $display("FAIL rstmid_hold k=%0d got dv=%b rd=%b exp 0 0", k, bus.DValid, bus.MemRead);
            end
        end
        bus.MemDone = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemAddr !== 16'h0400) begin
            errors++; $display("FAIL rstmid_regrant got rd=%b a=%h exp 1 0400", bus.MemRead, bus.MemAddr);
        end
        bus.MemDone = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.DValid !== 1'b1 || bus.DData !== 16'h4444) begin
            errors++; $display("FAIL rstmid_resp got dv=%b dd=%h exp 1 4444", bus.DValid, bus.DData);
        end
        tick();
        bus.DRd = 1'b0; bus.MemDone = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.DRd = 1'b1; bus.DAddr = 16'h0500; bus.MemDone = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.MemRead !== 1'b1 || (k == 0 && bus.Err !== 1'b0)) begin
                errors++; $display("FAIL to_busy k=%0d got rd=%b err=%b", k, bus.MemRead, bus.Err);
            end
            @(negedge clk);
            checks++;
            if (bus.DValid !== 1'b0 || bus.DStall !== 1'b1) begin
                errors++; $display("FAIL to_wait k=%0d got dv=%b ds=%b exp 0 1", k, bus.DValid, bus.DStall);
            end
            tick();
        end
        checks++;
        if (bus.MemRead !== 1'b0 || bus.Err !== 1'b1) begin
            errors++; $display("FAIL to_abort got rd=%b err=%b exp 0 1", bus.MemRead, bus.Err);
        end
        @(negedge clk);
        checks++;
        if (bus.DStall !== 1'b1 || bus.DValid !== 1'b0) begin
            errors++; $display("FAIL to_stall got ds=%b dv=%b exp 1 0", bus.DStall, bus.DValid);
        end
        tick();
        checks++;
        if (bus.MemRead !== 1'b1 || bus.MemAddr !== 16'h0500) begin
            errors++; $display("FAIL to_reissue got rd=%b a=%h exp 1 0500", bus.MemRead, bus.MemAddr);
        end
        bus.MemDone = 1'b1; bus.MemReadData = 16'h5555;
        @(negedge clk);
        checks++;
        if (bus.DValid !== 1'b1 || bus.DData !== 16'h5555) begin
            errors++; $display("FAIL to_resp got dv=%b dd=%h exp 1 5555", bus.DValid, bus.DData);
        end
        tick();
        bus.DRd = 1'b0; bus.MemDone = 1'b0;
        checks++;
        if (bus.Err !== 1'b1 || bus.MemRead !== 1'b0) begin
            errors++; $display("FAIL to_sticky got err=%b rd=%b exp 1 0", bus.Err, bus.MemRead);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.IReq = 1'b0; bus.IAddr = '0; bus.DRd = 1'b0; bus.DWr = 1'b0;
        bus.DAddr = '0; bus.DWData = '0; bus.MemReadData = '0; bus.MemDone = 1'b0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_simultaneous();
        test_random();
        test_conflict();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
